// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the iterative RV32M multiply/divide unit:
//            funct3 operation encodings and the control FSM state type.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // funct3[1] within the divide family selects the remainder
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational radix-2 iteration of the unsigned engine.
//            Multiply: conditional add of the multiplicand into the upper
//            half of the accumulator followed by a right shift.
//            Divide  : restoring step on {remainder, dividend/quotient}.
// Ports    : acc_i      2*XLEN  current accumulator
//            operand_i  XLEN    multiplicand (mul) or divisor (div)
//            div_mode_i 1       1 = divide step, 0 = multiply step
//            acc_o      2*XLEN  next accumulator (div: LSB left as 0)
//            qbit_o     1       quotient bit produced by a divide step
// Revision : 1.0  initial release
// ============================================================================
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_trial;

  always_comb begin
    // Multiply: one extra bit keeps the carry of the add before shifting.
    mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]}
              + (acc_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
    // Divide: bring the next dividend bit into the partial remainder.
    div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    div_trial = div_shift - {1'b0, operand_i};

    qbit_o = 1'b0;
    acc_o  = {mul_sum, acc_i[XLEN-1:1]};

    if (div_mode_i) begin
      // The partial remainder is always below the divisor, so the MSB of
      // the trial difference is exactly the borrow.
      qbit_o = ~div_trial[XLEN];
      if (qbit_o) begin
        acc_o = {div_trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {div_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Purpose  : Iterative RV32M multiply/divide unit beside the execute-stage
//            ALU. Operands are reduced to magnitudes on accept, run through
//            XLEN unsigned radix-2 steps, then sign-fixed and selected.
//            Divide-by-zero and signed overflow resolve in one cycle.
// Ports    : clk          clock
//            rst          synchronous active-high reset
//            in_valid_i   request valid        in_ready_o  accept (IDLE only)
//            op_i[2:0]    funct3 operation     a_i, b_i    rs1 / rs2 operands
//            flush_i      kill op, drop result
//            out_valid_o  result valid         out_ready_i consumer takes result
//            result_o     selected result      busy_o      CALC/FIX/DONE
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opd_q, opd_d;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;  // negate product / quotient
  logic                neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic [XLEN-1:0]     result_q, result_d;

  // Accept-time decode
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  // Engine and fix-up
  logic [2*XLEN-1:0] step_acc;
  logic              step_qbit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i      (acc_q),
    .operand_i  (opd_q),
    .div_mode_i (op_is_div(op_q)),
    .acc_o      (step_acc),
    .qbit_o     (step_qbit)
  );

  always_comb begin
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU)
            || (op_i == OP_DIV)  || (op_i == OP_REM);
    b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg    = a_signed & a_i[XLEN-1];
    b_neg    = b_signed & b_i[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1) as an unsigned
    // magnitude, which is exactly what the unsigned engine needs.
    abs_a    = a_neg ? (~a_i + 1'b1) : a_i;
    abs_b    = b_neg ? (~b_i + 1'b1) : b_i;

    div_zero = op_is_div(op_i) && (b_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM))
            && (a_i == MIN_NEG) && (b_i == '1);

    if (div_zero) begin
      special_res = op_is_rem(op_i) ? a_i : '1;
    end else begin
      special_res = op_is_rem(op_i) ? '0 : a_i;
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                         : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i && !flush_i) begin
          op_d      = op_i;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
          // Divide runs the dividend through the accumulator against the
          // divisor; multiply shifts the multiplier out against the
          // multiplicand.
          if (op_is_div(op_i)) begin
            opd_d = abs_b;
            acc_d = {{XLEN{1'b0}}, abs_a};
          end else begin
            opd_d = abs_a;
            acc_d = {{XLEN{1'b0}}, abs_b};
          end
        end
      end
      CALC: begin
        acc_d = op_is_div(op_q) ? {step_acc[2*XLEN-1:1], step_qbit} : step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = result_q;

endmodule
`default_nettype wire
